// File: rtl/inst_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : inst_boot_loader
//  Description : Boot-time program loader. Takes a byte stream carrying a
//                16-bit big-endian word count followed by that many big-endian
//                32-bit words, and writes each word into the instruction
//                Fetcher at consecutive word addresses. The CPU is held in
//                reset until the complete image has been written.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_boot_loader #(
  parameter int          DEPTH_WORDS    = 1024,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int          TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        load,
  output logic [31:0] load_addr,
  output logic [31:0] load_inst,
  output logic        cpu_rst,
  output logic        done,
  output logic        error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR0  = 3'd1;
  localparam logic [2:0] S_HDR1  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  localparam logic [31:0] C_DEPTH      = 32'(DEPTH_WORDS);
  localparam logic [31:0] C_TIMEOUT    = 32'(TIMEOUT_CYCLES);
  localparam bit          C_TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  logic [2:0]  r_state;
  logic [15:0] r_count;      // word count from the header
  logic [15:0] r_word_idx;   // index of the word currently being assembled
  logic [1:0]  r_byte_idx;   // byte position inside the current word
  logic [23:0] r_word;       // first three bytes of the current word
  logic [31:0] r_gap;        // idle cycles since the last transfer
  logic        r_load;
  logic [31:0] r_load_addr;
  logic [31:0] r_load_inst;

  logic        w_xfer;
  logic [15:0] w_count_full;
  logic [15:0] w_word_idx_next;
  logic [31:0] w_gap_next;
  logic        w_timeout;
  logic [31:0] w_addr;

  assign w_xfer          = byte_valid & byte_ready;
  assign w_count_full    = {r_count[15:8], byte_data};
  assign w_word_idx_next = r_word_idx + 16'd1;
  assign w_gap_next      = r_gap + 32'd1;
  // The transfer wins over a gap expiring in the same cycle.
  assign w_timeout       = C_TIMEOUT_EN && !w_xfer && (w_gap_next == C_TIMEOUT);
  // Byte address of the current word; 32-bit add wraps naturally.
  assign w_addr          = BASE_ADDR + {14'd0, r_word_idx, 2'b00};

  // Status outputs are pure decodes of the registered state.
  assign byte_ready = (r_state == S_HDR0) || (r_state == S_HDR1) || (r_state == S_DATA);
  assign cpu_rst    = (r_state != S_DONE);
  assign done       = (r_state == S_DONE);
  assign error      = (r_state == S_ERROR);
  assign load       = r_load;
  assign load_addr  = r_load_addr;
  assign load_inst  = r_load_inst;

  // Loader state machine, header/word assembly, load strobe and idle-gap timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_count     <= 16'd0;
      r_word_idx  <= 16'd0;
      r_byte_idx  <= 2'd0;
      r_word      <= 24'd0;
      r_gap       <= 32'd0;
      r_load      <= 1'b0;
      r_load_addr <= 32'd0;
      r_load_inst <= 32'd0;
    end else begin
      r_load <= 1'b0;
      case (r_state)
        S_IDLE, S_ERROR: begin
          if (start) begin
            r_state    <= S_HDR0;
            r_count    <= 16'd0;
            r_word_idx <= 16'd0;
            r_byte_idx <= 2'd0;
            r_word     <= 24'd0;
            r_gap      <= 32'd0;
          end
        end
        S_HDR0: begin
          // The gap timer only starts once the first byte has arrived.
          if (w_xfer) begin
            r_count[15:8] <= byte_data;
            r_gap         <= 32'd0;
            r_state       <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (w_xfer) begin
            r_count[7:0] <= byte_data;
            r_gap        <= 32'd0;
            if (w_count_full == 16'd0) begin
              r_state <= S_DONE;
            end else if ({16'd0, w_count_full} > C_DEPTH) begin
              r_state <= S_ERROR;
            end else begin
              r_state <= S_DATA;
            end
          end else if (w_timeout) begin
            r_state <= S_ERROR;
          end else if (C_TIMEOUT_EN) begin
            r_gap <= w_gap_next;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_gap      <= 32'd0;
            r_byte_idx <= r_byte_idx + 2'd1;
            r_word     <= {r_word[15:0], byte_data};
            if (r_byte_idx == 2'd3) begin
              r_load      <= 1'b1;
              r_load_inst <= {r_word, byte_data};
              r_load_addr <= w_addr;
              r_word_idx  <= w_word_idx_next;
              // Last word: the load strobe lands in the first DONE cycle.
              if (w_word_idx_next == r_count) begin
                r_state <= S_DONE;
              end
            end
          end else if (w_timeout) begin
            r_state <= S_ERROR;
          end else if (C_TIMEOUT_EN) begin
            r_gap <= w_gap_next;
          end
        end
        S_DONE: begin
          // Terminal until reset; start is ignored.
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
